// File: rtl/jt49_frac_cen.sv
// Fractional clock-enable generator: Bresenham accumulator emitting cen at clk*num/den,
// with a busy/err handshake to reprogram the ratio at a pulse boundary.
module jt49_frac_cen #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] num_in,
    input  logic [W-1:0] den_in,
    input  logic         upd,
    output logic         busy,
    output logic         err,
    output logic         cen,
    output logic [15:0]  pulses
);
    typedef enum logic {ST_IDLE, ST_PEND} state_t;

    state_t       r_state;
    logic [W-1:0] r_num;
    logic [W-1:0] r_den;
    logic [W-1:0] r_acc;
    logic [W-1:0] r_pnum;
    logic [W-1:0] r_pden;
    logic         r_busy;
    logic         r_err;
    logic         r_cen;
    logic [15:0]  r_pulses;

    logic [W:0]   w_sum;
    logic         w_wrap;
    logic [W-1:0] w_acc_nxt;
    logic         w_valid;
    logic         w_apply;

    // acc < den and num <= den, so the sum never exceeds W+1 bits
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_num};
    assign w_wrap    = (w_sum >= {1'b0, r_den});
    assign w_acc_nxt = w_wrap ? W'(w_sum - {1'b0, r_den}) : w_sum[W-1:0];
    assign w_valid   = upd && (den_in != '0) && (num_in <= den_in);
    // A disabled generator never wraps, so it takes the new ratio straight away
    assign w_apply   = w_wrap || (r_num == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_num    <= '0;
            r_den    <= W'(1);
            r_acc    <= '0;
            r_pnum   <= '0;
            r_pden   <= '0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_cen    <= 1'b0;
            r_pulses <= '0;
        end else begin
            r_cen    <= w_wrap;
            r_err    <= upd && !w_valid;
            r_pulses <= r_pulses + {15'd0, r_cen};
            r_acc    <= w_acc_nxt;
            if (r_state == ST_IDLE) begin
                if (w_valid) begin
                    r_pnum  <= num_in;
                    r_pden  <= den_in;
                    r_busy  <= 1'b1;
                    r_state <= ST_PEND;
                end
            end else begin
                // An upd landing on the apply cycle becomes the next pending ratio
                if (w_apply) begin
                    r_num <= r_pnum;
                    r_den <= r_pden;
                    r_acc <= '0;
                    if (!w_valid) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                if (w_valid) begin
                    r_pnum <= num_in;
                    r_pden <= den_in;
                end
            end
        end
    end

    assign busy   = r_busy;
    assign err    = r_err;
    assign cen    = r_cen;
    assign pulses = r_pulses;
endmodule

// File: tb/tb_jt49_frac_cen.sv
// Bench for jt49_frac_cen: closed-form phase model (pulse k fires when floor(k*num/den)
// steps) checked every cycle, plus directed scenarios with literal expectations.
module tb_jt49_frac_cen;
    localparam int W = 10;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] num_in;
    logic [W-1:0] den_in;
    logic         upd;
    logic         busy;
    logic         err;
    logic         cen;
    logic [15:0]  pulses;

    int checks = 0;
    int errors = 0;

    jt49_frac_cen #(.W(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .num_in (num_in),
        .den_in (den_in),
        .upd    (upd),
        .busy   (busy),
        .err    (err),
        .cen    (cen),
        .pulses (pulses)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Model: ratio num/den, phase k = clocks since the ratio was applied
    longint      m_num, m_den, m_k, m_pnum, m_pden;
    bit          m_pend, m_busy, m_err, m_cen, m_ready;
    logic [15:0] m_pulses;

    initial begin
        m_num = 0; m_den = 1; m_k = 0; m_pnum = 0; m_pden = 1;
        m_pend = 0; m_busy = 0; m_err = 0; m_cen = 0; m_ready = 0; m_pulses = '0;
    end

    always @(posedge clk) begin : model
        longint k1;
        bit     wrap;
        bit     valid;
        if (!rst_n) begin
            m_num <= 0; m_den <= 1; m_k <= 0; m_pend <= 0; m_busy <= 0;
            m_err <= 0; m_cen <= 0; m_pulses <= '0; m_ready <= 1;
        end else begin
            k1    = m_k + 1;
            wrap  = (m_num != 0) && ((k1 * m_num) / m_den != ((k1 - 1) * m_num) / m_den);
            valid = upd && (den_in != 0) && (num_in <= den_in);
            m_cen    <= wrap;
            m_err    <= upd && !valid;
            m_pulses <= m_pulses + 16'(m_cen);
            if (m_pend && (wrap || m_num == 0)) begin
                m_num <= m_pnum;
                m_den <= m_pden;
                m_k   <= 0;
                if (!valid) begin
                    m_pend <= 0;
                    m_busy <= 0;
                end
            end else begin
                m_k <= k1;
                if (valid) begin
                    m_pend <= 1;
                    m_busy <= 1;
                end
            end
            if (valid) begin
                m_pnum <= longint'(num_in);
                m_pden <= longint'(den_in);
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            check("m_cen", int'(cen), int'(m_cen));
            check("m_busy", int'(busy), int'(m_busy));
            check("m_err", int'(err), int'(m_err));
            check("m_pulses", int'(pulses), int'(m_pulses));
        end
    end

    task automatic do_upd(input int n, input int d);
        upd    = 1'b1;
        num_in = W'(n);
        den_in = W'(d);
        @(negedge clk);
        upd    = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output int n);
        n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("busy_timeout", int'(busy), 0);
    endtask

    initial begin
        int cnt;
        int first;
        int n;
        rst_n  = 1'b0;
        upd    = 1'b0;
        num_in = '0;
        den_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_cen", int'(cen), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        check("rst_pulses", int'(pulses), 0);

        // 1/4 from disabled: applies one cycle after upd, first pulse 4 clocks later
        do_upd(1, 4);
        check("t1_busy_hi", int'(busy), 1);
        @(negedge clk);
        check("t1_busy_lo", int'(busy), 0);
        cnt = 0;
        first = 0;
        for (int i = 1; i <= 101; i++) begin
            @(negedge clk);
            if (cen && first == 0) first = i;
            cnt += int'(cen);
        end
        check("t1_first", first, 4);
        check("t1_count", cnt, 25);
        check("t1_pulses", int'(pulses), 25);

        // 3/7: exactly 3 pulses in every 7-clock window
        do_upd(3, 7);
        wait_idle(20, n);
        for (int w = 0; w < 100; w++) begin
            cnt = 0;
            repeat (7) begin
                @(negedge clk);
                cnt += int'(cen);
            end
            check("t2_window", cnt, 3);
        end

        // 5/5 continuous, then disable
        do_upd(5, 5);
        wait_idle(20, n);
        repeat (2) @(negedge clk);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            cnt += int'(cen);
        end
        check("t3_full", cnt, 20);
        do_upd(0, 1);
        @(negedge clk);
        check("t3_applied", int'(busy), 0);
        check("t3_last_pulse", int'(cen), 1);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            cnt += int'(cen);
        end
        check("t3_off", cnt, 0);

        // 1/8 then 1/2 mid-period: held until the 8th clock, then every 2nd
        do_upd(1, 8);
        check("t4_busy_hi", int'(busy), 1);
        @(negedge clk);
        check("t4_applied", int'(busy), 0);
        repeat (3) @(negedge clk);
        do_upd(1, 2);
        check("t4_pend", int'(busy), 1);
        wait_idle(20, n);
        check("t4_wait", n, 4);
        check("t4_boundary_cen", int'(cen), 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t4_after", int'(cen), i % 2);
        end

        // Rejected updates
        cnt = 0;
        do_upd(1, 0);
        cnt += int'(err);
        @(negedge clk);
        cnt += int'(err);
        do_upd(9, 4);
        cnt += int'(err);
        @(negedge clk);
        cnt += int'(err);
        check("t5_err_count", cnt, 2);
        check("t5_busy", int'(busy), 0);

        // Reset while pending
        do_upd(1, 16);
        wait_idle(20, n);
        do_upd(1, 2);
        check("t6_pend", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_rst_cen", int'(cen), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_pulses", int'(pulses), 0);
        do_upd(3, 4);
        check("t6_busy_hi", int'(busy), 1);
        @(negedge clk);
        check("t6_applied", int'(busy), 0);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            cnt += int'(cen);
        end
        check("t6_count", cnt, 6);
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
